// File: rtl/vec_data_mem.sv
`default_nettype none
// vec_data_mem: word-wide synchronous data memory serving scalar (1 beat) and
// vector (LANES beats) load/store requests with a busy/done handshake.
module vec_data_mem #(
  parameter int ADDR_W = 13,
  parameter int LANES  = 16,
  parameter int DATA_W = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req,
  input  logic [ADDR_W-1:0]              addr,
  input  logic                           memWrite,
  input  logic                           vec_scalar,
  input  logic [LANES-1:0][DATA_W-1:0]   dataWrite_i,
  output logic [LANES-1:0][DATA_W-1:0]   dataRead_i,
  output logic                           busy,
  output logic                           done
);

  localparam int CNT_W = $clog2(LANES);

  typedef enum logic {IDLE = 1'b0, VEC = 1'b1} state_t;

  state_t                          state, state_next;
  logic [CNT_W-1:0]                beat, beat_next;
  logic [ADDR_W-1:0]               base;
  logic                            wr_lat;
  logic [LANES-1:0][DATA_W-1:0]    wdata_lat;
  logic [LANES-1:0][DATA_W-1:0]    rd_buf;

  logic [DATA_W-1:0]               mem [0:(1<<ADDR_W)-1];

  logic                            accept;
  logic                            scalar_rd;
  logic                            finish_vec;
  logic                            ram_en;
  logic                            ram_we;
  logic [ADDR_W-1:0]               ram_addr;
  logic [DATA_W-1:0]               ram_wdata;
  logic [CNT_W-1:0]                lane;

  always_comb begin
    state_next = state;
    beat_next  = beat;
    accept     = 1'b0;
    finish_vec = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = addr;
    lane       = CNT_W'(LANES - 1);
    ram_wdata  = dataWrite_i[LANES-1];
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (vec_scalar) begin
            state_next = VEC;
            beat_next  = '0;
          end else begin
            // Scalar accesses hit the RAM directly at the accepting edge.
            ram_en = 1'b1;
            ram_we = memWrite;
          end
        end
      end
      VEC: begin
        lane      = CNT_W'(LANES - 1) - beat;
        ram_en    = 1'b1;
        ram_we    = wr_lat;
        ram_addr  = base + ADDR_W'(beat);
        ram_wdata = wdata_lat[lane];
        beat_next = beat + 1'b1;
        if (beat == CNT_W'(LANES - 1)) begin
          state_next = IDLE;
          finish_vec = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign scalar_rd = accept && !vec_scalar && !memWrite;
  assign busy      = (state == VEC);

  always_ff @(posedge clk) begin
    if (rst && ram_en && ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      beat       <= '0;
      done       <= 1'b0;
      dataRead_i <= '0;
      base       <= '0;
      wr_lat     <= 1'b0;
      wdata_lat  <= '0;
      rd_buf     <= '0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
      done  <= (accept && !vec_scalar) || finish_vec;
      if (accept) begin
        base      <= addr;
        wr_lat    <= memWrite;
        wdata_lat <= dataWrite_i;
      end
      if (scalar_rd) begin
        dataRead_i            <= '0;
        dataRead_i[LANES-1]   <= mem[ram_addr];
      end
      if (busy && !wr_lat) begin
        rd_buf[lane] <= mem[ram_addr];
      end
      // The final beat bypasses rd_buf so the full vector appears with done.
      if (finish_vec && !wr_lat) begin
        dataRead_i       <= rd_buf;
        dataRead_i[lane] <= mem[ram_addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vec_data_mem.sv
`default_nettype none
// Scoreboard bench for vec_data_mem: stimulus pushes expected completions,
// a negedge monitor pops and compares on every done pulse.
module tb_vec_data_mem;

  localparam int AW = 13;
  localparam int L  = 16;
  localparam int DW = 32;

  typedef logic [L-1:0][DW-1:0] vec_t;
  typedef struct {
    bit   chk;
    vec_t data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          memWrite = 1'b0;
  logic          vec_scalar = 1'b0;
  vec_t          dataWrite_i = '0;
  vec_t          dataRead_i;
  logic          busy;
  logic          done;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] model [int];

  vec_data_mem #(.ADDR_W(AW), .LANES(L), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .memWrite(memWrite),
    .vec_scalar(vec_scalar), .dataWrite_i(dataWrite_i),
    .dataRead_i(dataRead_i), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [L*DW-1:0] act, input logic [L*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got=1 want=0");
      end else begin
        e = sb.pop_front();
        if (e.chk) chk("read_data", dataRead_i, e.data);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  task automatic scalar(input bit we, input int a, input logic [DW-1:0] d);
    exp_t e;
    addr        = AW'(a);
    memWrite    = we;
    vec_scalar  = 1'b0;
    dataWrite_i = '1;
    dataWrite_i[L-1] = d;
    req         = 1'b1;
    e.chk  = !we;
    e.data = '0;
    if (we) model[a] = d;
    else    e.data[L-1] = model[a];
    sb.push_back(e);
    @(posedge clk); #1;
    req = 1'b0;
    chk("scalar_done", done, 1);
    chk("scalar_busy", busy, 0);
  endtask

  task automatic vector(input bit we, input int base, input vec_t d, input int guard);
    exp_t e;
    int   nb;
    e.chk  = !we;
    e.data = '0;
    for (int k = 0; k < L; k++) begin
      if (we) model[(base + k) % (1 << AW)] = d[L-1-k];
      else    e.data[L-1-k] = model[(base + k) % (1 << AW)];
    end
    sb.push_back(e);
    addr        = AW'(base);
    memWrite    = we;
    vec_scalar  = 1'b1;
    dataWrite_i = d;
    req         = 1'b1;
    @(posedge clk); #1;
    req         = 1'b0;
    dataWrite_i = '1;
    addr        = '1;
    nb = 0;
    for (int j = 1; j <= L; j++) begin
      if (busy) nb++;
      if (j == guard) begin
        req        = 1'b1;
        memWrite   = 1'b1;
        vec_scalar = 1'b0;
        addr       = AW'(32'h200);
        dataWrite_i[L-1] = 32'hBAD0BAD0;
      end else begin
        req = 1'b0;
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    chk("vec_busy_cycles", nb, L);
    chk("vec_done", done, 1);
    chk("vec_busy_end", busy, 0);
  endtask

  initial begin : stim
    vec_t v;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_data", dataRead_i, '0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Scalar write then read
    scalar(1, 32'h0010, 32'hDEADBEEF);
    scalar(0, 32'h0010, '0);

    // Vector write/read with a guarded write attempt while busy
    scalar(1, 32'h0200, 32'h12345678);
    for (int k = 0; k < L; k++) v[L-1-k] = DW'(k + 1);
    vector(1, 32'h0100, v, 0);
    vector(0, 32'h0100, '0, 5);
    scalar(0, 32'h0200, '0);
    scalar(0, 32'h0105, '0);

    // Wrap-around
    for (int k = 0; k < L; k++) v[L-1-k] = DW'(32'hA000 + k);
    vector(1, 32'h1FF8, v, 0);
    scalar(0, 32'h1FFF, '0);
    scalar(0, 32'h0000, '0);
    scalar(0, 32'h0007, '0);

    // Reset aborts a vector write after four committed beats
    for (int k = 0; k < L; k++) v[L-1-k] = DW'(32'h1000 + k);
    vector(1, 32'h0300, v, 0);
    for (int k = 0; k < L; k++) v[k] = 32'h55;
    addr        = AW'(32'h0300);
    memWrite    = 1'b1;
    vec_scalar  = 1'b1;
    dataWrite_i = v;
    req         = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_data", dataRead_i, '0);
    for (int k = 0; k < 4; k++) model[32'h0300 + k] = 32'h55;
    vector(0, 32'h0300, '0, 0);

    // Back-to-back scalars
    for (int i = 0; i < 4; i++) scalar(1, 32'h0020 + i, DW'(i + 1));
    for (int i = 0; i < 4; i++) scalar(0, 32'h0020 + i, '0);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
